// File: rtl/riscv_fpu_issue_ctrl_if.sv
// Bus bundle between the FP issue controller, the integer pipeline front end,
// the FP execution unit and the register-file writeback port.
interface riscv_fpu_issue_ctrl_if #(
  parameter int unsigned XLEN = 64
);

  // Decoded instruction handshake
  logic            instr_valid;
  logic            instr_ready;
  logic [2:0]      instr_op;
  logic [2:0]      instr_funct3;
  logic [6:0]      instr_funct7;
  logic            instr_is_double;
  logic [4:0]      instr_rd;
  logic [XLEN-1:0] instr_rs1;
  logic [XLEN-1:0] instr_rs2;
  logic [XLEN-1:0] instr_rs3;

  // FPU request / response
  logic            fpu_enable;
  logic [2:0]      fpu_op;
  logic [2:0]      fpu_funct3;
  logic [6:0]      fpu_funct7;
  logic            fpu_is_double;
  logic [XLEN-1:0] fpu_rs1;
  logic [XLEN-1:0] fpu_rs2;
  logic [XLEN-1:0] fpu_rs3;
  logic [XLEN-1:0] fpu_result;
  logic            fpu_ready;
  logic [4:0]      fpu_flags;

  // Register-file writeback handshake
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic            wb_to_int;
  logic [XLEN-1:0] wb_data;

  // Controller side
  modport master (
    input  instr_valid, instr_op, instr_funct3, instr_funct7, instr_is_double, instr_rd,
    input  instr_rs1, instr_rs2, instr_rs3,
    output instr_ready,
    output fpu_enable, fpu_op, fpu_funct3, fpu_funct7, fpu_is_double,
    output fpu_rs1, fpu_rs2, fpu_rs3,
    input  fpu_result, fpu_ready, fpu_flags,
    output wb_valid, wb_rd, wb_to_int, wb_data,
    input  wb_ready
  );

  // Pipeline / FPU / register-file side
  modport slave (
    output instr_valid, instr_op, instr_funct3, instr_funct7, instr_is_double, instr_rd,
    output instr_rs1, instr_rs2, instr_rs3,
    input  instr_ready,
    input  fpu_enable, fpu_op, fpu_funct3, fpu_funct7, fpu_is_double,
    input  fpu_rs1, fpu_rs2, fpu_rs3,
    output fpu_result, fpu_ready, fpu_flags,
    input  wb_valid, wb_rd, wb_to_int, wb_data,
    output wb_ready
  );

endinterface

// File: rtl/riscv_fpu_issue_ctrl.sv
// Core-side FP issue controller: accepts a decoded FP instruction, resolves
// dynamic rounding, NaN-box-checks single operands, issues to the FPU with a
// response timeout, writes the result back and accrues sticky fflags.
module riscv_fpu_issue_ctrl #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  riscv_fpu_issue_ctrl_if.master     bus,
  input  logic [2:0]                 frm,
  output logic [4:0]                 fflags,
  input  logic                       fflags_clr,
  output logic                       illegal_instr,
  output logic                       fpu_timeout,
  output logic                       busy
);

  localparam logic [2:0] OpMisc = 3'd5;
  localparam logic [2:0] OpCmp  = 3'd6;
  localparam logic [2:0] OpCvt  = 3'd7;

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [XLEN-1:0] CanonNan = {{(XLEN-32){1'b1}}, 32'h7FC0_0000};

  typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic            is_double_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_q, rs2_q, rs3_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      flags_q;
  logic [4:0]      fflags_q;
  logic            enable_q;
  logic            wb_valid_q;
  logic            illegal_q;
  logic            timeout_q;
  logic [CntW-1:0] cnt_q;

  logic            accept;
  logic            uses_rm;
  logic [2:0]      rm_res;
  logic            rm_bad;
  logic            commit;
  logic            to_int;

  // Single-precision operand not properly NaN-boxed becomes the canonical NaN
  function automatic logic [XLEN-1:0] box_chk(input logic [XLEN-1:0] v, input logic dbl);
    if (!dbl && (v[XLEN-1:32] != {(XLEN-32){1'b1}})) begin
      return CanonNan;
    end
    return v;
  endfunction

  // Accept decode, rounding-mode resolution and writeback formatting
  always_comb begin
    accept  = bus.instr_valid && (state_q == StIdle);
    uses_rm = (bus.instr_op != OpMisc) && (bus.instr_op != OpCmp);
    rm_res  = (uses_rm && (bus.instr_funct3 == 3'b111)) ? frm : bus.instr_funct3;
    rm_bad  = uses_rm && (rm_res >= 3'd5);
    commit  = wb_valid_q && bus.wb_ready;
    to_int  = (op_q == OpCmp) || ((op_q == OpCvt) && (funct7_q[6:2] == 5'b11000));
  end

  // Controller FSM with registered request, writeback and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      is_double_q <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      fflags_q    <= '0;
      enable_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      // Clear and commit in one cycle leaves only the committed flags
      fflags_q  <= (fflags_clr ? 5'b0 : fflags_q) | (commit ? flags_q : 5'b0);
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (rm_bad) begin
              illegal_q <= 1'b1;
            end else begin
              op_q        <= bus.instr_op;
              funct3_q    <= rm_res;
              funct7_q    <= bus.instr_funct7;
              is_double_q <= bus.instr_is_double;
              rd_q        <= bus.instr_rd;
              rs1_q       <= box_chk(bus.instr_rs1, bus.instr_is_double);
              rs2_q       <= box_chk(bus.instr_rs2, bus.instr_is_double);
              rs3_q       <= box_chk(bus.instr_rs3, bus.instr_is_double);
              cnt_q       <= '0;
              enable_q    <= 1'b1;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          if (bus.fpu_ready) begin
            result_q   <= bus.fpu_result;
            flags_q    <= bus.fpu_flags;
            enable_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            state_q    <= StWb;
          end else if (cnt_q == CntMax) begin
            enable_q  <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWb: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          enable_q   <= 1'b0;
          wb_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  // Output drive from registered state
  always_comb begin
    bus.instr_ready   = (state_q == StIdle);
    bus.fpu_enable    = enable_q;
    bus.fpu_op        = op_q;
    bus.fpu_funct3    = funct3_q;
    bus.fpu_funct7    = funct7_q;
    bus.fpu_is_double = is_double_q;
    bus.fpu_rs1       = rs1_q;
    bus.fpu_rs2       = rs2_q;
    bus.fpu_rs3       = rs3_q;
    bus.wb_valid      = wb_valid_q;
    bus.wb_rd         = rd_q;
    bus.wb_to_int     = to_int;
    // Integer-bound single results drop the NaN-box and sign-extend
    bus.wb_data       = (to_int && !is_double_q) ?
                        {{(XLEN-32){result_q[31]}}, result_q[31:0]} : result_q;
    fflags            = fflags_q;
    illegal_instr     = illegal_q;
    fpu_timeout       = timeout_q;
    busy              = (state_q != StIdle);
  end

endmodule

// File: doc/riscv_fpu_issue_ctrl.md
Name: riscv_fpu_issue_ctrl

Overview:
Core-side initiator for the FP execution unit. It accepts decoded FP instructions from the integer pipeline with a valid/ready handshake and resolves dynamic rounding. It NaN-box-checks single-precision operands, drives the FPU request interface, waits for fpu_ready with a timeout, and returns the result to the FP or integer register file. It also accumulates sticky fflags for fcsr.

Parameters:
XLEN, 64, data width; must match the FPU.
TIMEOUT_CYCLES, 16, maximum ISSUE cycles waiting for fpu_ready before abort (>=2).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  decoded FP instruction available
instr_ready  out  1  block can accept an instruction
instr_op  in  3  FPU op code (ADD=0 … CVT=7)
instr_funct3  in  3  rm or sub-op
instr_funct7  in  7  funct7 field
instr_is_double  in  1  1 = D, 0 = S
instr_rd  in  5  destination register index
instr_rs1, instr_rs2, instr_rs3  in  XLEN  source operands
frm  in  3  fcsr dynamic rounding mode
fpu_enable  out  1  request valid to the FPU
fpu_op  out  3  op to the FPU
fpu_funct3  out  3  resolved rm or sub-op
fpu_funct7  out  7  funct7 to the FPU
fpu_is_double  out  1  precision to the FPU
fpu_rs1, fpu_rs2, fpu_rs3  out  XLEN  boxed-checked operands
fpu_result  in  XLEN  FPU result
fpu_ready  in  1  result/flags valid this cycle
fpu_flags  in  5  NV, DZ, OF, UF, NX
wb_valid  out  1  writeback pending
wb_ready  in  1  register file accepts writeback
wb_rd  out  5  destination index
wb_to_int  out  1  1 = integer register file, 0 = FP register file
wb_data  out  XLEN  writeback data
fflags  out  5  sticky accrued exception flags
fflags_clr  in  1  clear fflags (CSR write)
illegal_instr  out  1  one-cycle pulse: reserved rounding mode
fpu_timeout  out  1  one-cycle pulse: FPU did not respond
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset: state = IDLE; fpu_enable, wb_valid, illegal_instr and fpu_timeout = 0; fflags = 0; all data and control registers = 0; instr_ready = 1 in the cycle after reset deasserts. Reset mid-operation aborts with no writeback and no flag update. fpu_enable drops at the next edge.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready = 1. The only accept point is instr_valid && instr_ready.
  - On accept, register all instruction fields and operands.
  - Resolve rm: for op in {ADD, SUB, MUL, DIV, SQRT, CVT}, funct3 == 3'b111 is replaced by frm. MISC/CMP funct3 passes through unchanged.
  - If the resolved rm is 5, 6 or 7 on an rm-using op: stay in IDLE, pulse illegal_instr in the next cycle, no FPU request.
  - Otherwise go to ISSUE.
- NaN-box check (is_double = 0): an operand whose bits [63:32] != 32'hFFFF_FFFF is replaced by 64'hFFFF_FFFF_7FC0_0000 before driving fpu_rs*. Double operands pass unchanged.
- ISSUE:
  - fpu_enable = 1; all fpu_* outputs stay stable for the whole state.
  - The wait counter starts at 0 on entry and increments each ISSUE cycle.
  - On fpu_ready = 1: capture fpu_result and fpu_flags, go to WB.
  - If the counter reaches TIMEOUT_CYCLES-1 without fpu_ready: go to IDLE and pulse fpu_timeout next cycle. No writeback, no flags.
- Minimum latency with a combinational FPU (fpu_ready tied 1): accept at T, ISSUE at T+1, wb_valid at T+2. The next accept is no earlier than T+3 (after a wb handshake at T+2).
- WB:
  - wb_valid = 1; wb_rd, wb_to_int and wb_data are held until wb_ready.
  - On wb_valid && wb_ready: OR the captured flags into fflags, go to IDLE.
- wb_to_int = 1 for op CMP, and for op CVT with funct7[6:2] == 5'b11000. Otherwise 0.
- wb_data:
  - wb_to_int && !is_double: sign-extend captured result bits [31:0] to XLEN (strip the NaN-box).
  - All other cases: the captured result unchanged.
- fflags next = (fflags_clr ? 0 : fflags) | (commit ? captured_flags : 0). A clear and a commit in the same cycle leave only the committed flags.
- Timeout and illegal pulses never alter fflags.

Test Plan:
- Combinational FPU: ADD.D with funct3 = 3'b000, fpu_result = 64'h4008_0000_0000_0000, flags = 5'b00001 -> fpu_enable high at T+1, wb_valid at T+2 with wb_to_int = 0 and that data, fflags = 5'b00001 after the handshake.
- Single-precision CMP (op = 6), fpu_result = 64'hFFFF_FFFF_8000_0001 -> wb_to_int = 1, wb_data = 64'hFFFF_FFFF_8000_0001 sign-extended from the low 32 bits; result 64'hFFFF_FFFF_0000_0001 -> wb_data = 1.
- MUL.S with instr_rs1 = 64'h0000_0000_3F80_0000 (not boxed) -> fpu_rs1 = 64'hFFFF_FFFF_7FC0_0000.
- ADD with funct3 = 3'b111, frm = 3'b010 -> fpu_funct3 = 3'b010. Repeat with frm = 3'b101 -> illegal_instr pulses once, fpu_enable stays 0, instr_ready stays 1.
- fpu_ready held 0, TIMEOUT_CYCLES = 16 -> fpu_enable high exactly 16 cycles, then a fpu_timeout pulse, no wb_valid, fflags unchanged.
- wb_ready held 0 for 5 cycles with fflags_clr asserted on the handshake cycle (prior fflags = 5'b10000, new flags 5'b01000) -> wb outputs stable for 5 cycles, final fflags = 5'b01000. Assert rst during ISSUE -> next cycle IDLE, fpu_enable = 0, no writeback.
